// File: rtl/counter_pkg.sv
// Shared encodings for the general-purpose event/tick counter.
// Mode and direction constants used by counter_mod and its users.
package counter_pkg;

  typedef enum logic {
    MODE_WRAP     = 1'b0,
    MODE_SATURATE = 1'b1
  } mode_t;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/counter_mod_if.sv
// Control/status bundle for counter_mod; master drives controls, slave is the counter.
// prescale_tick exists only when COUNTER_MOD_PRESCALE_EN is defined.
interface counter_mod_if
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             enable;
  logic             up;
  mode_t            mode;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             max_wr;
  logic [WIDTH-1:0] max_value;
  logic             clr_ovf;
  logic [WIDTH-1:0] value;
  logic             tc;
  logic             overflow;
`ifdef COUNTER_MOD_PRESCALE_EN
  logic             prescale_tick;
`endif

  modport master (
    output enable, up, mode, load, load_value, max_wr, max_value, clr_ovf,
`ifdef COUNTER_MOD_PRESCALE_EN
    input  prescale_tick,
`endif
    input  value, tc, overflow
  );

  modport slave (
    input  enable, up, mode, load, load_value, max_wr, max_value, clr_ovf,
`ifdef COUNTER_MOD_PRESCALE_EN
    output prescale_tick,
`endif
    output value, tc, overflow
  );

endinterface

// File: rtl/counter_prescaler.sv
// Divides enabled cycles by PRESCALE; tick_out marks the enabled cycle that completes a period.
// Latency 0 (tick from registered phase); clear/reset restart the phase, enable=0 holds it.
module counter_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick_out
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt;

  assign tick_out = enable && (cnt == CW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (tick_out) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/counter_mod.sv
// Up/down modulus counter with wrap/saturate, load, terminal-count pulse and sticky overflow.
// Latency 1, no backpressure; optional prescaler under COUNTER_MOD_PRESCALE_EN.
module counter_mod
  import counter_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] MAX_DEFAULT = '1
`ifdef COUNTER_MOD_PRESCALE_EN
  ,
  parameter int               PRESCALE    = 4
`endif
) (
  input  logic         clk,
  input  logic         reset,
  counter_mod_if.slave bus
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_nxt;
  logic [WIDTH-1:0] max_reg;
  logic             tc_q;
  logic             ovf_q;
  logic             step;
  logic             evt;
  logic             sat;

`ifdef COUNTER_MOD_PRESCALE_EN
  logic tick;
  logic tick_q;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clear    (bus.load),
    .enable   (bus.enable),
    .tick_out (tick)
  );

  assign step = tick && !bus.load;

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= step;
    end
  end

  assign bus.prescale_tick = tick_q;
`else
  assign step = bus.enable && !bus.load;
`endif

  assign sat = (bus.mode == MODE_SATURATE);

  // A value left above a shrunken modulus is pulled back on the next step, in either direction.
  always_comb begin
    value_nxt = value_q;
    evt       = 1'b0;
    if (bus.load) begin
      value_nxt = (bus.load_value > max_reg) ? max_reg : bus.load_value;
    end else if (step) begin
      if (value_q > max_reg) begin
        value_nxt = max_reg;
      end else if (bus.up == DIR_UP) begin
        if (value_q == max_reg) begin
          evt       = 1'b1;
          value_nxt = sat ? value_q : '0;
        end else begin
          value_nxt = value_q + 1'b1;
        end
      end else begin
        if (value_q == '0) begin
          evt       = 1'b1;
          value_nxt = sat ? value_q : max_reg;
        end else begin
          value_nxt = value_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= RESET_VALUE;
      max_reg <= MAX_DEFAULT;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_nxt;
      tc_q    <= evt;
      if (bus.max_wr) begin
        max_reg <= bus.max_value;
      end
      if (evt) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.value    = value_q;
  assign bus.tc       = tc_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_counter_mod.sv
// Directed vector bench for counter_mod (default build, WIDTH=8, RESET_VALUE=0x05).
module tb_counter_mod;
  import counter_pkg::*;

  typedef struct {
    logic       rst;
    logic       en;
    logic       up;
    mode_t      mode;
    logic       ld;
    logic [7:0] ldv;
    logic       mw;
    logic [7:0] mv;
    logic       clr;
    logic [7:0] ev;
    logic       et;
    logic       eo;
  } vec_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   row;
  vec_t vecs[$];

  counter_mod_if #(.WIDTH(8)) bus ();

  counter_mod #(
    .WIDTH       (8),
    .RESET_VALUE (8'h05)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic rst, logic en, logic up, mode_t mode, logic ld,
                              logic [7:0] ldv, logic mw, logic [7:0] mv, logic clr,
                              logic [7:0] ev, logic et, logic eo);
    vec_t v;
    v.rst = rst; v.en = en; v.up = up; v.mode = mode; v.ld = ld; v.ldv = ldv;
    v.mw = mw; v.mv = mv; v.clr = clr; v.ev = ev; v.et = et; v.eo = eo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL row%0d %s: got %h, expected %h", row, nm, got, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    reset          = v.rst;
    bus.enable     = v.en;
    bus.up         = v.up;
    bus.mode       = v.mode;
    bus.load       = v.ld;
    bus.load_value = v.ldv;
    bus.max_wr     = v.mw;
    bus.max_value  = v.mv;
    bus.clr_ovf    = v.clr;
    @(posedge clk);
    #1;
    chk("value", bus.value, v.ev);
    chk("tc", {7'd0, bus.tc}, {7'd0, v.et});
    chk("overflow", {7'd0, bus.overflow}, {7'd0, v.eo});
    row++;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    row   = 0;

    // reset and idle hold
    for (int i = 0; i < 3; i++)  vecs.push_back(mk(1,0,DIR_UP,MODE_WRAP,0,0,0,0,0, 8'h05,0,0));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(0,0,DIR_UP,MODE_WRAP,0,0,0,0,0, 8'h05,0,0));
    // up wrap at modulus 9
    vecs.push_back(mk(0,0,DIR_UP,MODE_WRAP,1,0,1,9,0, 0,0,0));
    for (int i = 1; i <= 9; i++) vecs.push_back(mk(0,1,DIR_UP,MODE_WRAP,0,0,0,0,0, 8'(i),0,0));
    vecs.push_back(mk(0,1,DIR_UP,MODE_WRAP,0,0,0,0,0, 0,1,1));
    vecs.push_back(mk(0,1,DIR_UP,MODE_WRAP,0,0,0,0,0, 1,0,1));
    vecs.push_back(mk(0,0,DIR_UP,MODE_WRAP,0,0,0,0,1, 1,0,0));
    // down saturate from 3
    vecs.push_back(mk(0,0,DIR_DOWN,MODE_SATURATE,1,3,0,0,0, 3,0,0));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0,1,DIR_DOWN,MODE_SATURATE,0,0,0,0,0,
                        (i < 3) ? 8'(2 - i) : 8'd0, i >= 3, i >= 3));
    vecs.push_back(mk(0,1,DIR_DOWN,MODE_SATURATE,0,0,0,0,1, 0,1,1));
    vecs.push_back(mk(0,0,DIR_DOWN,MODE_SATURATE,0,0,0,0,1, 0,0,0));
    // priority: reset beats everything, load clamps, max_wr uses old max that cycle
    vecs.push_back(mk(1,1,DIR_UP,MODE_WRAP,1,8'h77,1,8'h10,1, 8'h05,0,0));
    vecs.push_back(mk(0,0,DIR_UP,MODE_WRAP,0,0,1,8'h20,0, 8'h05,0,0));
    vecs.push_back(mk(0,0,DIR_UP,MODE_WRAP,1,8'hFF,1,8'h40,0, 8'h20,0,0));
    vecs.push_back(mk(0,0,DIR_UP,MODE_WRAP,1,8'hFF,0,0,0, 8'h40,0,0));
    vecs.push_back(mk(0,1,DIR_UP,MODE_WRAP,1,8'hFF,0,0,0, 8'h40,0,0));
    // modulus shrink below current value
    vecs.push_back(mk(0,0,DIR_UP,MODE_WRAP,1,50,0,0,0, 50,0,0));
    vecs.push_back(mk(0,0,DIR_UP,MODE_WRAP,0,0,1,10,0, 50,0,0));
    vecs.push_back(mk(0,0,DIR_UP,MODE_WRAP,0,0,0,0,0, 50,0,0));
    vecs.push_back(mk(0,1,DIR_UP,MODE_WRAP,0,0,0,0,0, 10,0,0));
    vecs.push_back(mk(0,1,DIR_UP,MODE_WRAP,0,0,0,0,0, 0,1,1));
    vecs.push_back(mk(0,0,DIR_UP,MODE_WRAP,0,0,0,0,1, 0,0,0));
    // modulus 0: every step is a boundary event
    vecs.push_back(mk(0,1,DIR_UP,MODE_WRAP,0,0,1,0,0, 1,0,0));
    vecs.push_back(mk(0,1,DIR_UP,MODE_WRAP,0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,1,DIR_UP,MODE_WRAP,0,0,0,0,0, 0,1,1));
    vecs.push_back(mk(0,1,DIR_DOWN,MODE_WRAP,0,0,0,0,0, 0,1,1));
    vecs.push_back(mk(0,1,DIR_DOWN,MODE_SATURATE,0,0,0,0,0, 0,1,1));
    vecs.push_back(mk(0,0,DIR_DOWN,MODE_WRAP,0,0,0,0,1, 0,0,0));
    // down wrap lands on max
    vecs.push_back(mk(0,0,DIR_DOWN,MODE_WRAP,0,0,1,5,0, 0,0,0));
    vecs.push_back(mk(0,1,DIR_DOWN,MODE_WRAP,0,0,0,0,0, 5,1,1));
    vecs.push_back(mk(0,1,DIR_DOWN,MODE_WRAP,0,0,0,0,0, 4,0,1));
    vecs.push_back(mk(0,0,DIR_DOWN,MODE_WRAP,0,0,0,0,1, 4,0,0));

    foreach (vecs[i]) apply(vecs[i]);

    // saturated at max: tc re-pulses every enabled cycle, drops when enable does
    apply(mk(0,0,DIR_UP,MODE_SATURATE,1,5,0,0,0, 5,0,0));
    for (int i = 0; i < 4; i++) apply(mk(0,1,DIR_UP,MODE_SATURATE,0,0,0,0,0, 5,1,1));
    apply(mk(0,0,DIR_UP,MODE_SATURATE,0,0,0,0,0, 5,0,1));

    // full-width wrap at default modulus after reset
    apply(mk(1,1,DIR_UP,MODE_WRAP,0,0,0,0,0, 8'h05,0,0));
    apply(mk(0,0,DIR_UP,MODE_WRAP,1,8'hFF,0,0,0, 8'hFF,0,0));
    apply(mk(0,1,DIR_UP,MODE_WRAP,0,0,0,0,0, 8'h00,1,1));
    apply(mk(0,1,DIR_DOWN,MODE_WRAP,0,0,0,0,0, 8'hFF,1,1));
    apply(mk(0,1,DIR_DOWN,MODE_WRAP,0,0,0,0,1, 8'hFE,0,0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
